// File: rtl/spi_frame_ctrl.sv
// spi_frame_ctrl: multi-byte SPI frame controller in front of an 8-bit SPI
// byte engine. Accepts a frame request of 1..NBYTES bytes and asserts one of
// NCS active-low chip selects. The frame is sent most significant byte first
// through the spi_start/spi_busy handshake, and the received bytes are
// collected right-aligned. CS setup and idle time are programmable, each byte
// has a timeout, and a one-cycle done strobe marks the end of every frame,
// including aborted frames.
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   synchronous active-high reset
//   start         in   frame request, sampled only while idle
//   len           in   frame length in bytes (0 = ignored, clamped to NBYTES)
//   cs_sel        in   chip-select index
//   tx_data       in   transmit frame, byte k = tx_data[8k+7:8k]
//   spi_busy      in   byte engine busy
//   spi_data_out  in   byte received by the engine
//   busy          out  frame in progress
//   done          out  one-cycle end-of-frame strobe
//   err           out  invalid select or byte timeout on the last frame
//   rx_data       out  received frame, right-aligned
//   cs_n          out  active-low chip selects
//   spi_data_in   out  byte presented to the engine
//   spi_start     out  engine start request
module spi_frame_ctrl #(
    parameter int unsigned NBYTES     = 2,
    parameter int unsigned NCS        = 1,
    parameter int unsigned CS_SETUP   = 1,
    parameter int unsigned START_HOLD = 10,
    parameter int unsigned CS_IDLE    = 16,
    parameter int unsigned TIMEOUT    = 1023,
    localparam int unsigned SELW      = (NCS > 1) ? $clog2(NCS) : 1,
    localparam int unsigned LENW      = $clog2(NBYTES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LENW-1:0]       len,
    input  logic [SELW-1:0]       cs_sel,
    input  logic [8*NBYTES-1:0]   tx_data,
    input  logic                  spi_busy,
    input  logic [7:0]            spi_data_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [8*NBYTES-1:0]   rx_data,
    output logic [NCS-1:0]        cs_n,
    output logic [7:0]            spi_data_in,
    output logic                  spi_start
);

    localparam int unsigned RXW     = 8 * NBYTES;
    localparam int unsigned CNT_MAX = (CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE;
    localparam int unsigned CNTW    = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
    localparam int unsigned HOLDW   = $clog2(START_HOLD + 1);
    localparam int unsigned TOW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOAD,
        XFER,
        FINISH
    } state_e;

    state_e            state_q;
    logic [RXW-1:0]    tx_q;
    logic [RXW-1:0]    rx_q;
    logic [LENW-1:0]   rem_q;
    logic [CNTW-1:0]   cnt_q;
    logic [HOLDW-1:0]  hold_q;
    logic [TOW-1:0]    to_q;
    logic              spi_busy_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [NCS-1:0]    cs_n_q;
    logic [7:0]        spi_data_in_q;
    logic              spi_start_q;

    // Request decode and per-byte datapath values
    logic [LENW-1:0]   len_d;
    logic              sel_ok_d;
    logic [NCS-1:0]    cs_mask_d;
    logic [7:0]        byte_d;
    logic [RXW-1:0]    rx_d;
    logic              fall_d;

    always_comb begin
        len_d     = (32'(len) > NBYTES) ? LENW'(NBYTES) : len;
        sel_ok_d  = (32'(cs_sel) < NCS);
        cs_mask_d = ~(NCS'(1) << cs_sel);
        // Byte (remaining-1) of the latched frame; remaining is >= 1 in LOAD
        byte_d    = 8'(tx_q >> (32'd8 * (32'(rem_q) - 32'd1)));
        rx_d      = (rx_q << 8) | RXW'(spi_data_out);
        fall_d    = spi_busy_q & ~spi_busy;
    end

    // Frame sequencer with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            tx_q          <= '0;
            rx_q          <= '0;
            rem_q         <= '0;
            cnt_q         <= '0;
            hold_q        <= '0;
            to_q          <= '0;
            spi_busy_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            cs_n_q        <= '1;
            spi_data_in_q <= '0;
            spi_start_q   <= 1'b0;
        end else begin
            spi_busy_q <= spi_busy;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && (len != '0)) begin
                        if (sel_ok_d) begin
                            tx_q    <= tx_data;
                            rem_q   <= len_d;
                            rx_q    <= '0;
                            err_q   <= 1'b0;
                            busy_q  <= 1'b1;
                            cs_n_q  <= cs_mask_d;
                            cnt_q   <= '0;
                            state_q <= SETUP;
                        end else begin
                            // Unreachable chip select: report and end at once
                            err_q  <= 1'b1;
                            done_q <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    if (32'(cnt_q) + 32'd1 >= CS_SETUP) begin
                        cnt_q   <= '0;
                        state_q <= LOAD;
                    end else begin
                        cnt_q <= cnt_q + CNTW'(1);
                    end
                end
                LOAD: begin
                    spi_data_in_q <= byte_d;
                    spi_start_q   <= 1'b0;
                    hold_q        <= '0;
                    to_q          <= '0;
                    state_q       <= XFER;
                end
                XFER: begin
                    if (fall_d) begin
                        // Byte complete, accepted even inside the hold window
                        rx_q        <= rx_d;
                        spi_start_q <= 1'b0;
                        rem_q       <= rem_q - LENW'(1);
                        if (rem_q > LENW'(1)) begin
                            state_q <= LOAD;
                        end else begin
                            cs_n_q  <= '1;
                            cnt_q   <= '0;
                            state_q <= FINISH;
                        end
                    end else if (32'(to_q) + 32'd1 >= TIMEOUT) begin
                        // Engine never finished: abandon the rest of the frame
                        err_q       <= 1'b1;
                        spi_start_q <= 1'b0;
                        cs_n_q      <= '1;
                        cnt_q       <= '0;
                        state_q     <= FINISH;
                    end else begin
                        to_q <= to_q + TOW'(1);
                        if (32'(hold_q) < START_HOLD) begin
                            spi_start_q <= 1'b1;
                            hold_q      <= hold_q + HOLDW'(1);
                        end else begin
                            spi_start_q <= 1'b0;
                        end
                    end
                end
                FINISH: begin
                    if (32'(cnt_q) + 32'd1 >= CS_IDLE) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNTW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign rx_data     = rx_q;
    assign cs_n        = cs_n_q;
    assign spi_data_in = spi_data_in_q;
    assign spi_start   = spi_start_q;

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Directed self-checking bench for spi_frame_ctrl. A second instance with
// three chip selects exercises an out-of-range cs_sel, which a two-select
// instance cannot express on its 1-bit cs_sel port.
module tb_spi_frame_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  len = '0;
    logic        cs_sel = 1'b0;
    logic [15:0] tx_data = '0;
    logic        spi_busy = 1'b0;
    logic [7:0]  spi_data_out = '0;
    logic        busy, done, err;
    logic [15:0] rx_data;
    logic [1:0]  cs_n;
    logic [7:0]  spi_data_in;
    logic        spi_start;

    logic        start2 = 1'b0;
    logic [1:0]  cs_sel2 = '0;
    logic        spi_busy2 = 1'b0;
    logic [7:0]  spi_data_out2 = '0;
    logic        busy2, done2, err2;
    logic [15:0] rx_data2;
    logic [2:0]  cs_n2;
    logic [7:0]  spi_data_in2;
    logic        spi_start2;

    int n_cmp = 0;
    int n_err = 0;

    spi_frame_ctrl #(.NBYTES(2), .NCS(2)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .cs_sel(cs_sel),
        .tx_data(tx_data), .spi_busy(spi_busy), .spi_data_out(spi_data_out),
        .busy(busy), .done(done), .err(err), .rx_data(rx_data), .cs_n(cs_n),
        .spi_data_in(spi_data_in), .spi_start(spi_start)
    );

    spi_frame_ctrl #(.NBYTES(2), .NCS(3)) dut3 (
        .clk(clk), .reset(reset), .start(start2), .len(len), .cs_sel(cs_sel2),
        .tx_data(tx_data), .spi_busy(spi_busy2), .spi_data_out(spi_data_out2),
        .busy(busy2), .done(done2), .err(err2), .rx_data(rx_data2), .cs_n(cs_n2),
        .spi_data_in(spi_data_in2), .spi_start(spi_start2)
    );

    always #5 clk = ~clk;

    // Byte engine model plus activity monitor, on the falling edge
    bit        eng_hang = 1'b0;
    int        eng_cnt = 0;
    logic [7:0] eng_byte = '0;
    logic      prev_start = 1'b0;
    logic      prev_busy = 1'b0;
    logic [1:0] prev_csn = 2'b11;
    int        cyc = 0;
    int        hi_cnt = 0;
    int        nb = 0;
    int        done_cnt = 0;
    int        busy_rise_cyc = 0;
    int        csn_rise_cyc = 0;
    int        done_cyc = 0;
    logic [7:0] data_log [0:63];
    logic [1:0] cs_log   [0:63];
    int        len_log   [0:63];
    int        scyc_log  [0:63];

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            spi_busy = 1'b0;
            eng_cnt  = 0;
        end else begin
            if (eng_cnt > 0) eng_cnt--;
            if (spi_busy && eng_cnt == 0 && !eng_hang) begin
                spi_busy     = 1'b0;
                spi_data_out = ~eng_byte;
            end
            if (spi_start && !prev_start) begin
                eng_byte = spi_data_in;
                spi_busy = 1'b1;
                eng_cnt  = 20;
            end
        end
        if (spi_start) hi_cnt++;
        else if (prev_start) begin
            if (nb > 0) len_log[nb-1] = hi_cnt;
            hi_cnt = 0;
        end
        if (spi_start && !prev_start && nb < 63) begin
            data_log[nb] = spi_data_in;
            cs_log[nb]   = cs_n;
            scyc_log[nb] = cyc;
            nb++;
        end
        if (busy && !prev_busy) busy_rise_cyc = cyc;
        if (cs_n == 2'b11 && prev_csn != 2'b11) csn_rise_cyc = cyc;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_start = spi_start;
        prev_busy  = busy;
        prev_csn   = cs_n;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int nb_base = 0;
    int done_base = 0;

    task automatic launch(input logic [15:0] tx, input logic [1:0] l, input logic sel);
        nb_base   = nb;
        done_base = done_cnt;
        tx_data   = tx;
        len       = l;
        cs_sel    = sel;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (done_cnt != done_base) seen = 1'b1;
        end
        check(tag, 64'(seen), 64'd1);
    endtask

    initial begin
        // Reset values
        tick();
        tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_rx", 64'(rx_data), 64'd0);
        check("rst_csn", 64'(cs_n), 64'h3);
        check("rst_sdi", 64'(spi_data_in), 64'd0);
        check("rst_sstart", 64'(spi_start), 64'd0);
        check("rst_csn3", 64'(cs_n2), 64'h7);
        reset = 1'b0;
        tick();

        // Two-byte frame on select 1
        launch(16'hA55A, 2'd2, 1'b1);
        check("a_busy", 64'(busy), 64'd1);
        check("a_csn", 64'(cs_n), 64'h1);
        wait_done("a_done_seen", 300);
        check("a_done_width", 64'(done), 64'd0);
        tick(); tick();
        check("a_done_cnt", 64'(done_cnt - done_base), 64'd1);
        check("a_rx", 64'(rx_data), 64'h5AA5);
        check("a_err", 64'(err), 64'd0);
        check("a_busy_end", 64'(busy), 64'd0);
        check("a_csn_end", 64'(cs_n), 64'h3);
        check("a_bursts", 64'(nb - nb_base), 64'd2);
        check("a_byte0", 64'(data_log[nb_base]), 64'hA5);
        check("a_byte1", 64'(data_log[nb_base+1]), 64'h5A);
        check("a_hold0", 64'(len_log[nb_base]), 64'd10);
        check("a_hold1", 64'(len_log[nb_base+1]), 64'd10);
        check("a_cs0", 64'(cs_log[nb_base]), 64'h1);
        check("a_cs1", 64'(cs_log[nb_base+1]), 64'h1);
        check("a_latency", 64'(scyc_log[nb_base] - busy_rise_cyc), 64'd3);
        check("a_idle", 64'(done_cyc - csn_rise_cyc), 64'd16);

        // Single-byte frame sends only the low byte
        launch(16'h1234, 2'd1, 1'b0);
        wait_done("b_done_seen", 300);
        check("b_rx", 64'(rx_data), 64'h00CB);
        check("b_bursts", 64'(nb - nb_base), 64'd1);
        check("b_byte0", 64'(data_log[nb_base]), 64'h34);
        check("b_cs0", 64'(cs_log[nb_base]), 64'h2);

        // Oversize length clamps to two bytes
        launch(16'h0FF0, 2'd3, 1'b1);
        wait_done("c_done_seen", 300);
        check("c_rx", 64'(rx_data), 64'hF00F);
        check("c_bursts", 64'(nb - nb_base), 64'd2);
        check("c_byte0", 64'(data_log[nb_base]), 64'h0F);

        // Zero length is ignored
        launch(16'hFFFF, 2'd0, 1'b1);
        check("d_busy", 64'(busy), 64'd0);
        check("d_csn", 64'(cs_n), 64'h3);
        for (int i = 0; i < 30; i++) tick();
        check("d_bursts", 64'(nb - nb_base), 64'd0);
        check("d_done", 64'(done_cnt - done_base), 64'd0);
        check("d_rx", 64'(rx_data), 64'hF00F);
        check("d_err", 64'(err), 64'd0);

        // Out-of-range select on the three-select instance
        len     = 2'd2;
        cs_sel2 = 2'd3;
        start2  = 1'b1;
        tick();
        start2  = 1'b0;
        check("e_done", 64'(done2), 64'd1);
        check("e_err", 64'(err2), 64'd1);
        check("e_busy", 64'(busy2), 64'd0);
        tick();
        check("e_done_width", 64'(done2), 64'd0);
        for (int i = 0; i < 10; i++) tick();
        check("e_csn", 64'(cs_n2), 64'h7);
        check("e_sstart", 64'(spi_start2), 64'd0);
        check("e_err_hold", 64'(err2), 64'd1);

        // Byte timeout: engine never releases busy
        eng_hang = 1'b1;
        launch(16'hA55A, 2'd2, 1'b0);
        check("f_csn", 64'(cs_n), 64'h2);
        wait_done("f_done_seen", 1300);
        check("f_err", 64'(err), 64'd1);
        check("f_busy", 64'(busy), 64'd0);
        check("f_csn_end", 64'(cs_n), 64'h3);
        check("f_bursts", 64'(nb - nb_base), 64'd1);
        check("f_rx", 64'(rx_data), 64'd0);
        check("f_idle", 64'(done_cyc - csn_rise_cyc), 64'd16);
        eng_hang = 1'b0;
        for (int i = 0; i < 5; i++) tick();

        // Start while busy is ignored
        launch(16'hA55A, 2'd2, 1'b1);
        check("g_err_clr", 64'(err), 64'd0);
        for (int i = 0; i < 5; i++) tick();
        tx_data = 16'hFFFF;
        len     = 2'd1;
        cs_sel  = 1'b0;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        wait_done("g_done_seen", 300);
        check("g_rx", 64'(rx_data), 64'h5AA5);
        check("g_bursts", 64'(nb - nb_base), 64'd2);
        check("g_byte1", 64'(data_log[nb_base+1]), 64'h5A);
        check("g_cs1", 64'(cs_log[nb_base+1]), 64'h1);

        // Reset in the middle of a byte transfer
        launch(16'h1357, 2'd2, 1'b1);
        begin
            bit hit = 1'b0;
            for (int i = 0; i < 50 && !hit; i++) begin
                tick();
                if (spi_start === 1'b1) hit = 1'b1;
            end
            check("h_sstart_seen", 64'(hit), 64'd1);
        end
        reset = 1'b1;
        tick();
        check("h_busy", 64'(busy), 64'd0);
        check("h_sstart", 64'(spi_start), 64'd0);
        check("h_csn", 64'(cs_n), 64'h3);
        check("h_sdi", 64'(spi_data_in), 64'd0);
        check("h_rx", 64'(rx_data), 64'd0);
        check("h_err", 64'(err), 64'd0);
        check("h_done", 64'(done), 64'd0);
        reset = 1'b0;
        tick(); tick();
        check("h_no_done", 64'(done_cnt - done_base), 64'd0);
        launch(16'h0012, 2'd1, 1'b1);
        wait_done("h2_done_seen", 300);
        check("h2_rx", 64'(rx_data), 64'h00ED);
        check("h2_err", 64'(err), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
